// File: rtl/jt49_pkg.sv
// Shared definitions for the jt49 envelope sequencer: FSM state encoding,
// envelope shape bit positions and the shape-latch helper.
package jt49_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Shape register bit positions, {CONT,ATT,ALT,HOLD}
    localparam int CONT    = 3;
    localparam int ATT     = 2;
    localparam int ALT     = 1;
    localparam int HOLD    = 0;
    localparam int SHAPE_W = 4;

    // Maps the written shape nibble onto the EG control bits by name, so a
    // future reordering of the EG control word only touches this function.
    function automatic logic [SHAPE_W-1:0] shape_latch(input logic [SHAPE_W-1:0] din);
        logic [SHAPE_W-1:0] s;
        s       = '0;
        s[CONT] = din[CONT];
        s[ATT]  = din[ATT];
        s[ALT]  = din[ALT];
        s[HOLD] = din[HOLD];
        return s;
    endfunction

endpackage

// File: rtl/jt49_env_seq_if.sv
// Register-file side bus of the envelope sequencer: period/shape write
// strobes in, EG control outputs back.
interface jt49_env_seq_if #(
    parameter int CNTW = 16
);
    import jt49_pkg::*;

    logic               period_wr;
    logic [CNTW-1:0]    period_din;
    logic               shape_wr;
    logic [SHAPE_W-1:0] shape_din;
    logic               eg_cen;
    logic               eg_rst_n;
    logic [SHAPE_W-1:0] eg_ctrl;
    logic               running;

    modport master (
        output period_wr, period_din, shape_wr, shape_din,
        input  eg_cen, eg_rst_n, eg_ctrl, running
    );

    modport slave (
        input  period_wr, period_din, shape_wr, shape_din,
        output eg_cen, eg_rst_n, eg_ctrl, running
    );

endinterface

// File: rtl/jt49_env_div.sv
// Envelope timebase: a 2**PRESC_W prescaler on cen followed by a period
// counter. step is combinational and marks the cen pulse on which the
// period counter wraps.
module jt49_env_div
    import jt49_pkg::*;
#(
    parameter int CNTW    = 16,
    parameter int PRESC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            cen,
    input  logic [CNTW-1:0] period,
    output logic            step
);

    localparam logic [CNTW:0]      CNT_ONE   = (CNTW+1)'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc;
    logic [CNTW-1:0]    cnt;
    logic [CNTW:0]      eff_p;
    logic [CNTW:0]      cnt_inc;
    logic               tick;
    logic               wrap;

    // Period 0 behaves as 1; the compare runs one bit wider so cnt+1 never
    // overflows at the maximum period.
    assign eff_p   = (period == '0) ? CNT_ONE : {1'b0, period};
    assign cnt_inc = {1'b0, cnt} + CNT_ONE;
    assign tick    = en && cen && (presc == '1);
    assign wrap    = (cnt_inc >= eff_p);
    assign step    = tick && wrap;

    // Prescaler and period counter; cleared while the sequencer restarts.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            presc <= '0;
            cnt   <= '0;
        end else if (en && cen) begin
            presc <= presc + PRESC_ONE;
            if (presc == '1) begin
                cnt <= wrap ? '0 : cnt_inc[CNTW-1:0];
            end
        end
    end

endmodule

// File: rtl/jt49_env_seq.sv
// Envelope sequencer for jt49_eg: latches period and shape, restarts the EG
// on every shape write and produces the registered EG step enable.
// Optional feature: define JT49_ENV_PAUSE_EN to add a `pause` input that
// freezes the timebase while in RUN.
module jt49_env_seq
    import jt49_pkg::*;
#(
    parameter int CNTW    = 16,
    parameter int PRESC_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
`ifdef JT49_ENV_PAUSE_EN
    input  logic pause,
`endif
    jt49_env_seq_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic [CNTW-1:0]    period;
    logic [SHAPE_W-1:0] ctrl;
    logic               step;
    logic               step_p1;
    logic               run_p1;
    logic               hold;
    logic               div_clr;
    logic               div_en;

`ifdef JT49_ENV_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign div_clr = (state == ST_RESTART);
    assign div_en  = (state == ST_RUN) && !hold;

    jt49_env_div #(
        .CNTW    (CNTW),
        .PRESC_W (PRESC_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (div_clr),
        .en     (div_en),
        .cen    (cen),
        .period (period),
        .step   (step)
    );

    // Next-state logic: any shape write (re)enters RESTART, which lasts one clk.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.shape_wr) state_nxt = ST_RESTART;
            ST_RESTART: state_nxt = bus.shape_wr ? ST_RESTART : ST_RUN;
            ST_RUN:     if (bus.shape_wr) state_nxt = ST_RESTART;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Period latch, accepted in every state; the counter keeps its value.
    always_ff @(posedge clk) begin
        if (!rst_n)             period <= '0;
        else if (bus.period_wr) period <= bus.period_din;
    end

    // Shape latch feeding the EG control word.
    always_ff @(posedge clk) begin
        if (!rst_n)            ctrl <= '0;
        else if (bus.shape_wr) ctrl <= shape_latch(bus.shape_din);
    end

    // ---- stage p1: registered EG step enable and run/reset outputs ----
    // A shape write in the same clk as a wrapping tick discards that step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_p1 <= 1'b0;
            run_p1  <= 1'b0;
        end else begin
            step_p1 <= step && !bus.shape_wr;
            run_p1  <= (state_nxt == ST_RUN);
        end
    end

    assign bus.eg_cen   = step_p1;
    assign bus.eg_rst_n = run_p1;
    assign bus.running  = run_p1;
    assign bus.eg_ctrl  = ctrl;

endmodule
